// File: rtl/divider_pkg.sv
// divider_pkg: shared types and sizes for the sequential divider
package divider_pkg;
  localparam int DIV_WIDTH = 8;
  localparam int DIV_CNT_W = 4;
  typedef enum logic [1:0] {IDLE, RUN, DONE} div_state_t;
endpackage

// File: rtl/addsub_8.sv
// addsub_8: 8-bit adder/subtractor, co is carry out (no borrow when subtracting)
module addsub_8 (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sub,
  output logic [7:0] s,
  output logic       co,
  output logic       ofl
);
  logic [7:0] bb;
  assign bb = b ^ {8{sub}};
  assign {co, s} = {1'b0, a} + {1'b0, bb} + {8'd0, sub};
  assign ofl = (a[7] == bb[7]) && (s[7] != a[7]);
endmodule

// File: rtl/divider_8_seq.sv
// divider_8_seq: restoring unsigned divider, one quotient bit per clock
module divider_8_seq
  import divider_pkg::*;
#(
  parameter int WIDTH = DIV_WIDTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero
);
  div_state_t state;
  logic [WIDTH-1:0] q, r, d, sh, diff;
  logic [DIV_CNT_W-1:0] count;
  logic co, take, zero;
  assign sh = {r[WIDTH-2:0], q[WIDTH-1]};
  assign take = r[WIDTH-1] | co;
  assign zero = divisor == '0;
  addsub_8 u_sub (.a(sh), .b(d), .sub(1'b1), .s(diff), .co(co), .ofl());
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= IDLE;
      q <= '0;
      r <= '0;
      d <= '0;
      count <= '0;
      done <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      done <= state == DONE;
      case (state)
        IDLE: if (start) begin
          q <= zero ? '1 : dividend;
          r <= zero ? dividend : '0;
          d <= divisor;
          count <= '0;
          div_by_zero <= zero;
          state <= zero ? DONE : RUN;
        end
        RUN: begin
          r <= take ? diff : sh;
          q <= {q[WIDTH-2:0], take};
          count <= count + 1'b1;
          state <= count == DIV_CNT_W'(WIDTH - 1) ? DONE : RUN;
        end
        default: state <= IDLE;
      endcase
    end
  // the done cycle is spent in IDLE so a new start can be taken on its closing edge
  assign busy = state != IDLE || done;
  assign quotient = q;
  assign remainder = r;
endmodule
